// File: rtl/float_to_fixed.sv
// Iterative IEEE-754 single to 32-bit two's-complement fixed-point converter.
// One right shift per cycle; special values resolve in a single SHIFT cycle.
module float_to_fixed (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] float_in,
  input  logic [7:0]  exp_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] fixed_out,
  output logic        overflow
);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_SHIFT = 1'b1;

  logic        state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        sign_q, sign_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic        done_q, done_d;
  logic [31:0] fixed_q, fixed_d;
  logic        ovf_q, ovf_d;

  logic [7:0]  e_in;
  logic [22:0] f_in;
  logic [9:0]  cnt_calc;
  logic        cnt_le0;
  logic        cnt_ge32;
  logic [31:0] sat_mag;

  assign e_in     = float_in[30:23];
  assign f_in     = float_in[22:0];
  // Mod-2^10 arithmetic; bit 9 is the sign of the signed shift count.
  assign cnt_calc = 10'd158 + {{2{exp_in[7]}}, exp_in} - {2'b00, e_in};
  assign cnt_le0  = cnt_calc[9] || (cnt_calc == 10'd0);
  assign cnt_ge32 = !cnt_calc[9] && (cnt_calc >= 10'd32);
  // Negative saturation stores 0x80000000, which negates to itself.
  assign sat_mag  = float_in[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;

  always_comb begin
    state_d    = state_q;
    mag_d      = mag_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    ovf_pend_d = ovf_pend_q;
    done_d     = 1'b0;
    fixed_d    = fixed_q;
    ovf_d      = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_SHIFT;
          sign_d     = float_in[31];
          cnt_d      = 10'd0;
          mag_d      = 32'd0;
          ovf_pend_d = 1'b0;
          if (e_in == 8'd0) begin
            mag_d = 32'd0;
          end else if (e_in == 8'hFF) begin
            ovf_pend_d = 1'b1;
            if (f_in == 23'd0) mag_d = sat_mag;
          end else if (cnt_le0) begin
            mag_d      = sat_mag;
            ovf_pend_d = 1'b1;
          end else if (cnt_ge32) begin
            mag_d = 32'd0;
          end else begin
            mag_d = {1'b1, f_in, 8'b0};
            cnt_d = cnt_calc;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q != 10'd0) begin
          mag_d = mag_q >> 1;
          cnt_d = cnt_q - 10'd1;
        end else begin
          fixed_d = sign_q ? (32'd0 - mag_q) : mag_q;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mag_q      <= 32'd0;
      cnt_q      <= 10'd0;
      sign_q     <= 1'b0;
      ovf_pend_q <= 1'b0;
      done_q     <= 1'b0;
      fixed_q    <= 32'd0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mag_q      <= mag_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      ovf_pend_q <= ovf_pend_d;
      done_q     <= done_d;
      fixed_q    <= fixed_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = done_q;
  assign fixed_out = fixed_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Directed bench for float_to_fixed: hand-computed vectors, latency, hold,
// mid-conversion start and reset abort.
module tb_float_to_fixed;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] float_in;
  logic [7:0]  exp_in;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] fixed_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  float_to_fixed dut (
    .clk       (clk),
    .rst       (rst),
    .float_in  (float_in),
    .exp_in    (exp_in),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .fixed_out (fixed_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
  endtask

  task automatic run(input string tag, input logic [31:0] f, input logic [7:0] e,
                     input logic [31:0] exp_fx, input logic exp_ov, input int exp_lat);
    int n;
    @(negedge clk);
    float_in = f; exp_in = e; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; float_in = ~f; exp_in = ~e;
    chk({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
    wait_done(n);
    chk({tag, " latency"}, n, exp_lat);
    chk({tag, " fixed_out"}, fixed_out, exp_fx);
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ov});
    chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b1; start = 1'b0; float_in = 32'd0; exp_in = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset fixed_out", fixed_out, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    @(negedge clk); rst = 1'b0;

    run("one",      32'h3F80_0000, 8'h00, 32'h0000_0001, 1'b0, 32);
    run("neg5",     32'hC0A0_0000, 8'h00, 32'hFFFF_FFFB, 1'b0, 30);
    run("pi_q16",   32'h4049_0FDB, 8'hF0, 32'h0003_243F, 1'b0, 15);
    run("hundred",  32'h42C8_0000, 8'h02, 32'h0000_0019, 1'b0, 28);
    run("neg2p75",  32'hC030_0000, 8'h00, 32'hFFFF_FFFE, 1'b0, 31);
    run("two31",    32'h4F00_0000, 8'h00, 32'h7FFF_FFFF, 1'b1, 1);
    run("neg_inf",  32'hFF80_0000, 8'h00, 32'h8000_0000, 1'b1, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("hold done_low", {31'd0, done}, 32'd0);
    chk("hold fixed_out", fixed_out, 32'h8000_0000);
    chk("hold overflow", {31'd0, overflow}, 32'd1);

    run("neg_two31", 32'hCF00_0000, 8'h00, 32'h8000_0000, 1'b1, 1);
    run("half",      32'h3F00_0000, 8'h00, 32'h0000_0000, 1'b0, 1);
    run("zero",      32'h0000_0000, 8'h00, 32'h0000_0000, 1'b0, 1);
    run("nan",       32'h7FC0_0000, 8'h00, 32'h0000_0000, 1'b1, 1);
    run("one_exp1",  32'h3F80_0000, 8'h01, 32'h0000_0000, 1'b0, 1);

    // Second start mid-conversion must be ignored.
    @(negedge clk);
    float_in = 32'h3F80_0000; exp_in = 8'h00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    float_in = 32'h42C8_0000; exp_in = 8'h02; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(n);
    chk("midstart latency", n + 6, 32);
    chk("midstart fixed_out", fixed_out, 32'h0000_0001);
    repeat (3) @(posedge clk);
    #1;
    chk("midstart no_restart", {31'd0, busy}, 32'd0);

    // Reset in the middle of SHIFT aborts immediately.
    run("pre_reset", 32'h4049_0FDB, 8'hF0, 32'h0003_243F, 1'b0, 15);
    @(negedge clk);
    float_in = 32'h3F80_0000; exp_in = 8'h00; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst fixed_out", fixed_out, 32'd0);
    @(posedge clk); #1;
    chk("rst start_ignored", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("rst no_done", pulses, 0);
    chk("rst idle", {31'd0, busy}, 32'd0);

    run("post_reset", 32'h4049_0FDB, 8'hF0, 32'h0003_243F, 1'b0, 15);
    run("backtoback", 32'hC0A0_0000, 8'h00, 32'hFFFF_FFFB, 1'b0, 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
